// File: rtl/fabric_row_sequencer_pkg.sv
// Shared types and default widths for the per-row program loader/launcher.
package fabric_row_sequencer_pkg;

    localparam int unsigned INSTR_DATA_WIDTH   = 32;
    localparam int unsigned INSTR_ADDR_WIDTH   = 4;
    localparam int unsigned INSTR_HOPS_WIDTH   = 4;
    localparam int unsigned INSTR_WORD_WIDTH   = INSTR_HOPS_WIDTH + INSTR_ADDR_WIDTH + INSTR_DATA_WIDTH;

    localparam int unsigned SEQ_MEM_ADDR_WIDTH = 10;
    localparam int unsigned SEQ_LEN_WIDTH      = 10;
    localparam int unsigned SEQ_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        ISSUE    = 3'd2,
        CALL     = 3'd3,
        WAIT_RET = 3'd4
    } state_t;

    typedef struct packed {
        logic [INSTR_HOPS_WIDTH-1:0] hops;
        logic [INSTR_ADDR_WIDTH-1:0] addr;
        logic [INSTR_DATA_WIDTH-1:0] data;
    } instr_word_t;

endpackage

// File: rtl/fabric_row_sequencer_watchdog.sv
// Row return edge detector plus the WAIT_RET watchdog counter.
module row_ret_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic ret,
    output logic ret_rise,
    output logic expired
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_ret_prev;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // ret is sampled during clear too, so a ret already high at launch is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_ret_prev <= 1'b0;
        end else if (clear) begin
            r_cnt      <= '0;
            r_ret_prev <= ret;
        end else if (enable) begin
            r_cnt      <= w_cnt_inc;
            r_ret_prev <= ret;
        end
    end

    assign ret_rise = enable && ret && !r_ret_prev;
    assign expired  = enable && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fabric_row_sequencer.sv
// Fetches a program block from instruction memory, injects it into a fabric row, then calls and waits for ret.
module fabric_row_sequencer
    import fabric_row_sequencer_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = SEQ_MEM_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH      = SEQ_LEN_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = SEQ_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [MEM_ADDR_WIDTH-1:0]   start_addr,
    input  logic [LEN_WIDTH-1:0]        length,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic                        mem_req,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    input  logic                        mem_valid,
    input  logic [INSTR_WORD_WIDTH-1:0] mem_rdata,
    output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
    output logic                        instr_en_out,
    output logic                        call,
    input  logic                        ret
);
    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [MEM_ADDR_WIDTH-1:0] w_addr_nxt;
    logic [LEN_WIDTH-1:0]      r_remaining;
    logic [LEN_WIDTH-1:0]      w_remaining_nxt;
    logic                      w_load;
    logic                      w_done_nxt;
    logic                      w_timeout_nxt;
    logic                      w_ret_rise;
    logic                      w_expired;
    instr_word_t               w_mem_word;

    assign w_mem_word = instr_word_t'(mem_rdata);

    row_ret_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (r_state == CALL),
        .enable   (r_state == WAIT_RET),
        .ret      (ret),
        .ret_rise (w_ret_rise),
        .expired  (w_expired)
    );

    // Next-state and next-output decode; outputs are registered from these values
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_load          = 1'b0;
        w_done_nxt      = 1'b0;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                // the cycle carrying a done/timeout pulse does not accept a new start
                if (start && !done && !timeout) begin
                    w_addr_nxt      = start_addr;
                    w_remaining_nxt = length;
                    w_state_nxt     = (length == '0) ? CALL : FETCH;
                end
            end
            FETCH: begin
                if (mem_req && mem_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_addr_nxt      = r_addr + MEM_ADDR_WIDTH'(1);
                w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
                w_state_nxt     = (r_remaining == LEN_WIDTH'(1)) ? CALL : FETCH;
            end
            CALL: begin
                w_state_nxt = WAIT_RET;
            end
            WAIT_RET: begin
                if (w_ret_rise) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            instr_data_out <= '0;
            instr_addr_out <= '0;
            instr_hops_out <= '0;
            instr_en_out   <= 1'b0;
            call           <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_remaining  <= w_remaining_nxt;
            busy         <= (w_state_nxt != IDLE);
            done         <= w_done_nxt;
            timeout      <= w_timeout_nxt;
            mem_req      <= (w_state_nxt == FETCH);
            instr_en_out <= (w_state_nxt == ISSUE);
            call         <= (w_state_nxt == CALL);
            if (w_state_nxt == FETCH) begin
                mem_addr <= w_addr_nxt;
            end
            // the instruction outputs double as the capture register for the fetched word
            if (w_load) begin
                instr_data_out <= w_mem_word.data;
                instr_addr_out <= w_mem_word.addr;
                instr_hops_out <= w_mem_word.hops;
            end
        end
    end

endmodule

// File: tb/tb_fabric_row_sequencer.sv
// Scoreboard bench for fabric_row_sequencer: randomized memory latency and ret timing against a queue-based model.
module tb_fabric_row_sequencer;
    import fabric_row_sequencer_pkg::*;

    localparam int unsigned TB_TIMEOUT = 12;
    localparam int unsigned MAW        = SEQ_MEM_ADDR_WIDTH;
    localparam int unsigned LENW       = SEQ_LEN_WIDTH;
    localparam int unsigned WW         = INSTR_WORD_WIDTH;
    localparam int          MEM_WORDS  = 1 << MAW;

    typedef struct {
        bit is_done;
        int delay;
    } end_t;

    logic                        clk;
    logic                        rst_n;
    logic                        start;
    logic [MAW-1:0]              start_addr;
    logic [LENW-1:0]             length;
    logic                        busy;
    logic                        done;
    logic                        timeout;
    logic                        mem_req;
    logic [MAW-1:0]              mem_addr;
    logic                        mem_valid;
    logic [WW-1:0]               mem_rdata;
    logic [INSTR_DATA_WIDTH-1:0] instr_data_out;
    logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out;
    logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out;
    logic                        instr_en_out;
    logic                        call;
    logic                        ret;

    fabric_row_sequencer #(
        .MEM_ADDR_WIDTH (MAW),
        .LEN_WIDTH      (LENW),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_addr     (start_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_valid      (mem_valid),
        .mem_rdata      (mem_rdata),
        .instr_data_out (instr_data_out),
        .instr_addr_out (instr_addr_out),
        .instr_hops_out (instr_hops_out),
        .instr_en_out   (instr_en_out),
        .call           (call),
        .ret            (ret)
    );

    logic [WW-1:0] mem [MEM_WORDS];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    bit            rst_at_edge = 1'b0;
    int            mem_lat_max = 1;

    int            exp_addr_q [$];
    logic [WW-1:0] exp_word_q [$];
    int            exp_call_q [$];
    end_t          exp_end_q  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !rst_n;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: one response per request after 1..mem_lat_max cycles, noise on idle bus
    bit pending = 1'b0;
    int lat_cnt = 0;
    initial begin
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            mem_rdata = WW'({$urandom, $urandom});
            if (!mem_req) begin
                pending = 1'b0;
                if ($urandom_range(0, 3) == 0) mem_valid = 1'b1;
            end else if (!pending) begin
                pending = 1'b1;
                lat_cnt = $urandom_range(1, mem_lat_max);
            end else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem[mem_addr];
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event
    bit   prev_req    = 1'b0;
    int   req_exp     = 0;
    int   last_en_cyc = 0;
    int   call_cyc    = 0;
    int   mon_e;
    end_t mon_r;
    always @(negedge clk) begin
        if (rst_at_edge) begin
            check("reset_outputs_zero",
                  64'({busy, done, timeout, mem_req, mem_addr, instr_data_out,
                       instr_addr_out, instr_hops_out, instr_en_out, call}), 64'(0));
            prev_req = 1'b0;
        end else begin
            if (mem_req) begin
                if (!prev_req) begin
                    if (exp_addr_q.size() == 0) begin
                        check("mem_req_unexpected", 64'(mem_req), 64'(0));
                        req_exp = int'(mem_addr);
                    end else begin
                        req_exp = exp_addr_q.pop_front();
                        check("mem_addr", 64'(mem_addr), 64'(req_exp));
                    end
                end else begin
                    check("mem_addr_stable", 64'(mem_addr), 64'(req_exp));
                end
            end
            prev_req = mem_req;
            if (instr_en_out) begin
                if (exp_word_q.size() == 0)
                    check("instr_en_unexpected", 64'(instr_en_out), 64'(0));
                else
                    check("instr_word", 64'({instr_hops_out, instr_addr_out, instr_data_out}),
                          64'(exp_word_q.pop_front()));
                last_en_cyc = cyc;
            end
            if (call) begin
                if (exp_call_q.size() == 0) begin
                    check("call_unexpected", 64'(call), 64'(0));
                end else begin
                    mon_e = exp_call_q.pop_front();
                    if (mon_e < 0) mon_e = last_en_cyc + 1;
                    check("call_cycle", 64'(cyc), 64'(mon_e));
                    check("words_before_call", 64'(exp_word_q.size()), 64'(0));
                end
                check("busy_at_call", 64'(busy), 64'(1));
                call_cyc = cyc;
            end
            if (done || timeout) begin
                if (exp_end_q.size() == 0) begin
                    check("end_unexpected", 64'({done, timeout}), 64'(0));
                end else begin
                    mon_r = exp_end_q.pop_front();
                    check("end_kind", 64'({done, timeout}), mon_r.is_done ? 64'(2) : 64'(1));
                    check("end_delay", 64'(cyc - call_cyc), 64'(mon_r.delay));
                end
                check("busy_at_end", 64'(busy), 64'(0));
            end
        end
    end

    task automatic tick(input bit noise);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (noise && busy && $urandom_range(0, 3) == 0) begin
            start      = 1'b1;
            start_addr = MAW'($urandom);
            length     = LENW'($urandom_range(0, 7));
        end
    endtask

    // ret_delay < 0: ret held high through the whole run; else ret rises ret_delay cycles after call
    task automatic run(input int sa, input int len, input int ret_delay, input bit noise, input bit poke);
        end_t er;
        int   g;
        int   k;
        for (int i = 0; i < len; i++) begin
            exp_addr_q.push_back((sa + i) % MEM_WORDS);
            exp_word_q.push_back(mem[(sa + i) % MEM_WORDS]);
        end
        exp_call_q.push_back(len == 0 ? cyc + 1 : -1);
        if (ret_delay > 0 && ret_delay <= int'(TB_TIMEOUT) - 1) begin
            er.is_done = 1'b1;
            er.delay   = ret_delay + 1;
        end else begin
            er.is_done = 1'b0;
            er.delay   = int'(TB_TIMEOUT);
        end
        exp_end_q.push_back(er);

        start_addr = MAW'(sa);
        length     = LENW'(len);
        start      = 1'b1;
        if (ret_delay < 0) ret = 1'b1;
        g = 0;
        do begin
            tick(noise);
            g++;
        end while (!call && g < 500);
        check("call_seen", 64'(call), 64'(1));
        k = 0;
        while (!(done || timeout) && k < int'(TB_TIMEOUT) + 5) begin
            tick(noise);
            k++;
            if (ret_delay > 0 && k == ret_delay) ret = 1'b1;
        end
        check("end_seen", 64'(done | timeout), 64'(1));
        if (poke) begin
            start      = 1'b1;
            start_addr = MAW'($urandom);
            length     = LENW'(2);
        end
        tick(0);
        ret = 1'b0;
        tick(0);
        tick(0);
        if (poke) check("start_at_end_ignored", 64'(busy), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = WW'({$urandom, $urandom});
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        ret        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0);

        mem_lat_max = 1;
        run(5, 3, 10, 0, 1);
        run(100, 0, 5, 0, 0);
        run(MEM_WORDS - 1, 2, 4, 0, 0);
        run(7, 1, -1, 0, 0);
        run(40, 1, int'(TB_TIMEOUT) - 1, 0, 0);
        run(41, 1, int'(TB_TIMEOUT), 0, 0);

        mem_lat_max = 5;
        for (int r = 0; r < 10; r++) begin
            int sa;
            int len;
            int rd;
            sa  = $urandom_range(0, MEM_WORDS - 1);
            len = $urandom_range(0, 6);
            rd  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(1, TB_TIMEOUT + 2);
            run(sa, len, rd, 1, r[0]);
        end

        // reset while the second word is being fetched
        begin
            int rises;
            bit pq;
            for (int i = 0; i < 3; i++) begin
                exp_addr_q.push_back(200 + i);
                exp_word_q.push_back(mem[200 + i]);
            end
            exp_call_q.push_back(-1);
            start_addr = MAW'(200);
            length     = LENW'(3);
            start      = 1'b1;
            rises      = 0;
            pq         = 1'b0;
            for (int g = 0; g < 200 && rises < 2; g++) begin
                tick(0);
                if (mem_req && !pq) rises++;
                pq = mem_req;
            end
            check("second_fetch_reached", 64'(rises), 64'(2));
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            exp_addr_q.delete();
            exp_word_q.delete();
            exp_call_q.delete();
            exp_end_q.delete();
            repeat (TB_TIMEOUT + 3) tick(0);
            check("idle_after_reset", 64'(busy), 64'(0));
        end
        run(300, 3, 6, 1, 0);

        check("addr_q_drained", 64'(exp_addr_q.size()), 64'(0));
        check("word_q_drained", 64'(exp_word_q.size()), 64'(0));
        check("call_q_drained", 64'(exp_call_q.size()), 64'(0));
        check("end_q_drained",  64'(exp_end_q.size()),  64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got still running expected finished");
        $fatal(1, "time limit");
    end

endmodule
